// File: rtl/multicycle_controller.sv
// Multi-cycle RV32 subset controller: fetches over a req/ready port, decodes the
// latched instruction and sequences control strobes for the existing datapath.
module multicycle_controller #(
    parameter int TIMEOUT   = 16,
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    input  logic                 imem_ready,
    input  logic [31:0]          imem_rdata,
    output logic                 dmem_req,
    output logic                 dmem_we,
    input  logic                 dmem_ready,
    input  logic                 zero,
    output logic [31:0]          ir,
    output logic [2:0]           alu_op,
    output logic                 alu_src,
    output logic [1:0]           imm_sel,
    output logic                 rf_we,
    output logic                 wb_sel,
    output logic                 pc_we,
    output logic                 pc_src,
    output logic                 illegal,
    output logic                 bus_error,
    output logic [INSTRET_W-1:0] retired,
    output logic [2:0]           state_check
);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEMORY    = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    typedef enum logic [2:0] {K_R, K_I, K_LW, K_SW, K_BEQ, K_BAD} kind_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_SLT = 3'd7;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] WAIT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT - 1) : '0;

    state_t           state, next_state;
    kind_t            kind;
    logic [2:0]       dec_op;
    logic             dec_src;
    logic [1:0]       dec_sel;
    logic [CNT_W-1:0] wait_cnt;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic             retire, waiting, timeout_hit, set_illegal;

    assign funct3      = ir[14:12];
    assign funct7      = ir[31:25];
    assign state_check = state;

    function automatic logic [2:0] f3_to_op(input logic [2:0] f3);
        case (f3)
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    // Instruction class and ALU controls depend only on the latched ir.
    always_comb begin
        kind    = K_BAD;
        dec_op  = ALU_ADD;
        dec_src = 1'b0;
        dec_sel = 2'd0;
        case (ir[6:0])
            7'b0110011: begin
                dec_op = f3_to_op(funct3);
                if (funct3 == 3'b000 && funct7 == 7'h20) begin
                    kind   = K_R;
                    dec_op = ALU_SUB;
                end else if (funct7 == 7'h00 && funct3 != 3'b011) begin
                    kind = K_R;
                end
            end
            7'b0010011: begin
                dec_op  = f3_to_op(funct3);
                dec_src = 1'b1;
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    if (funct7 == 7'h00) kind = K_I;
                end else if (funct3 != 3'b011) begin
                    kind = K_I;
                end
            end
            7'b0000011: begin
                dec_src = 1'b1;
                if (funct3 == 3'b010) kind = K_LW;
            end
            7'b0100011: begin
                dec_src = 1'b1;
                dec_sel = 2'd1;
                if (funct3 == 3'b010) kind = K_SW;
            end
            7'b1100011: begin
                dec_op  = ALU_SUB;
                dec_sel = 2'd2;
                if (funct3 == 3'b000) kind = K_BEQ;
            end
            default: ;
        endcase
    end

    // Everything is gated by reset so strobes drop the instant reset asserts.
    always_comb begin
        next_state  = state;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = 1'b0;
        pc_we       = 1'b0;
        pc_src      = 1'b0;
        alu_op      = ALU_ADD;
        alu_src     = 1'b0;
        imm_sel     = 2'd0;
        retire      = 1'b0;
        waiting     = 1'b0;
        timeout_hit = 1'b0;
        set_illegal = 1'b0;
        if (reset) begin
            if (state inside {EXECUTE, MEMORY, WRITEBACK}) begin
                alu_op  = dec_op;
                alu_src = dec_src;
                imm_sel = dec_sel;
            end
            case (state)
                FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ready) next_state = DECODE;
                    else            waiting    = 1'b1;
                end
                DECODE: begin
                    if (kind == K_BAD) begin
                        set_illegal = 1'b1;
                        next_state  = HALT;
                    end else begin
                        next_state = EXECUTE;
                    end
                end
                EXECUTE: begin
                    case (kind)
                        K_BEQ: begin
                            pc_we      = 1'b1;
                            pc_src     = zero;
                            retire     = 1'b1;
                            next_state = FETCH;
                        end
                        K_LW, K_SW: next_state = MEMORY;
                        default:    next_state = WRITEBACK;
                    endcase
                end
                MEMORY: begin
                    dmem_req = 1'b1;
                    dmem_we  = (kind == K_SW);
                    if (!dmem_ready) begin
                        waiting = 1'b1;
                    end else if (kind == K_SW) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        next_state = FETCH;
                    end else begin
                        next_state = WRITEBACK;
                    end
                end
                WRITEBACK: begin
                    rf_we      = (ir[11:7] != 5'd0);
                    wb_sel     = (kind == K_LW);
                    pc_we      = 1'b1;
                    retire     = 1'b1;
                    next_state = FETCH;
                end
                HALT:    next_state = HALT;
                default: next_state = HALT;
            endcase
            if (waiting && TIMEOUT_EN && wait_cnt == WAIT_LAST) begin
                timeout_hit = 1'b1;
                next_state  = HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            ir        <= '0;
            retired   <= '0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state <= next_state;
            if (state == FETCH && imem_ready) ir <= imem_rdata;
            if (retire) retired <= retired + INSTRET_W'(1);
            if (set_illegal) illegal <= 1'b1;
            if (timeout_hit) bus_error <= 1'b1;
            if (waiting && TIMEOUT_EN && !timeout_hit) wait_cnt <= wait_cnt + CNT_W'(1);
            else                                        wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level model predicts the
// per-cycle output trace, plus hand-computed spot checks on key results.
module tb_multicycle_controller;

    localparam int TIMEOUT = 16;
    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BAD = 5;
    localparam logic [2:0] OP_TAB [8] = '{3'd0, 3'd5, 3'd7, 3'd0, 3'd4, 3'd6, 3'd3, 3'd2};

    logic        clk, reset;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, zero;
    logic [31:0] imem_rdata, ir, retired;
    logic [2:0]  alu_op, state_check;
    logic        alu_src, rf_we, wb_sel, pc_we, pc_src, illegal, bus_error;
    logic [1:0]  imm_sel;

    multicycle_controller #(.TIMEOUT(TIMEOUT), .INSTRET_W(32)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .zero(zero), .ir(ir), .alu_op(alu_op), .alu_src(alu_src), .imm_sel(imm_sel),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_src(pc_src),
        .illegal(illegal), .bus_error(bus_error), .retired(retired),
        .state_check(state_check)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        ireq, dreq, dwe, rfwe, wbsel, pcwe, pcsrc, ill, berr;
        logic [2:0]  op;
        logic        chk, src;
        logic [1:0]  sel;
        logic [31:0] ret;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] prog_i[$];
    int          prog_fw[$], prog_mw[$];
    int          fidx, icnt, dcnt;
    bit          iready_always;
    int          m_retired;
    bit          m_illegal, m_bus_err;
    int          tests, fails;
    int          cyc, n_ireq, n_dreq, n_rfwe, n_pcwe, last_pcwe_cyc;
    logic        last_pc_src;
    int          start_cyc, b_ireq, b_dreq, b_rfwe, b_pcwe;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    function automatic void model_decode(input logic [31:0] i, output int kind,
                                         output logic [2:0] op, output logic src,
                                         output logic [1:0] sel);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = i[14:12];
        f7 = i[31:25];
        kind = K_BAD; op = 3'd0; src = 1'b0; sel = 2'd0;
        case (i[6:0])
            7'h33: if ((f7 == 7'h00 && f3 != 3'd3) || (f3 == 3'd0 && f7 == 7'h20)) begin
                kind = K_R;
                op   = (f7 == 7'h20) ? 3'd1 : OP_TAB[f3];
            end
            7'h13: if (f3 != 3'd3 && (f7 == 7'h00 || (f3 != 3'd1 && f3 != 3'd5))) begin
                kind = K_I; op = OP_TAB[f3]; src = 1'b1;
            end
            7'h03: if (f3 == 3'd2) begin kind = K_LW; src = 1'b1; end
            7'h23: if (f3 == 3'd2) begin kind = K_SW; src = 1'b1; sel = 2'd1; end
            7'h63: if (f3 == 3'd0) begin kind = K_BEQ; op = 3'd1; sel = 2'd2; end
            default: ;
        endcase
    endfunction

    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e      = '0;
        e.st   = st;
        e.ill  = m_illegal;
        e.berr = m_bus_err;
        e.ret  = 32'(m_retired);
        return e;
    endfunction

    // Expand one instruction into the output trace it must produce, cycle by cycle.
    task automatic build(input logic [31:0] instr, input int fw, input int mw, input int halt_n);
        int kind, nf, nm;
        logic [2:0] op;
        logic src;
        logic [1:0] sel;
        exp_t e, c;
        model_decode(instr, kind, op, src, sel);
        nf = (fw < 0 || fw >= TIMEOUT) ? TIMEOUT : fw + 1;
        for (int k = 0; k < nf; k++) begin e = mk(3'd0); e.ireq = 1'b1; exp_q.push_back(e); end
        if (fw < 0 || fw >= TIMEOUT) begin
            m_bus_err = 1'b1;
            for (int k = 0; k < halt_n; k++) exp_q.push_back(mk(3'd5));
            return;
        end
        exp_q.push_back(mk(3'd1));
        if (kind == K_BAD) begin
            m_illegal = 1'b1;
            for (int k = 0; k < halt_n; k++) exp_q.push_back(mk(3'd5));
            return;
        end
        c = mk(3'd2); c.op = op; c.chk = 1'b1; c.src = src; c.sel = sel;
        if (kind == K_BEQ) begin
            c.pcwe = 1'b1; c.pcsrc = zero;
            exp_q.push_back(c);
            m_retired++;
            return;
        end
        exp_q.push_back(c);
        if (kind == K_LW || kind == K_SW) begin
            nm = (mw < 0 || mw >= TIMEOUT) ? TIMEOUT : mw + 1;
            for (int k = 0; k < nm; k++) begin
                e = c; e.st = 3'd3; e.ret = 32'(m_retired);
                e.dreq = 1'b1; e.dwe = (kind == K_SW);
                e.pcwe = (kind == K_SW) && (k == nm - 1) && (mw >= 0 && mw < TIMEOUT);
                exp_q.push_back(e);
            end
            if (mw < 0 || mw >= TIMEOUT) begin
                m_bus_err = 1'b1;
                for (int k = 0; k < halt_n; k++) exp_q.push_back(mk(3'd5));
                return;
            end
            if (kind == K_SW) begin m_retired++; return; end
        end
        e = c; e.st = 3'd4;
        e.rfwe = (instr[11:7] != 5'd0); e.wbsel = (kind == K_LW); e.pcwe = 1'b1;
        exp_q.push_back(e);
        m_retired++;
    endtask

    task automatic queue_instr(input logic [31:0] instr, input int fw, input int mw, input int halt_n);
        prog_i.push_back(instr); prog_fw.push_back(fw); prog_mw.push_back(mw);
        build(instr, fw, mw, halt_n);
    endtask

    task automatic reset_all();
        reset = 1'b0;
        exp_q.delete(); prog_i.delete(); prog_fw.delete(); prog_mw.delete();
        fidx = 0; icnt = 0; dcnt = 0; iready_always = 1'b0;
        imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = 32'h0; zero = 1'b0;
        m_retired = 0; m_illegal = 1'b0; m_bus_err = 1'b0;
    endtask

    // Memory responder: answers each request after the programmed number of wait cycles.
    task automatic apply_stimulus();
        int fw, mw;
        fw = (fidx < prog_i.size()) ? prog_fw[fidx] : -1;
        imem_rdata = (fidx < prog_i.size()) ? prog_i[fidx] : 32'h0;
        imem_ready = iready_always || (imem_req && fw >= 0 && icnt == fw);
        if (imem_req && imem_ready) begin fidx++; icnt = 0; end
        else if (imem_req)          icnt++;
        else                        icnt = 0;
        mw = (fidx > 0 && fidx <= prog_i.size()) ? prog_mw[fidx-1] : -1;
        dmem_ready = dmem_req && mw >= 0 && dcnt == mw;
        if (dmem_req && !dmem_ready) dcnt++;
        else                         dcnt = 0;
    endtask

    task automatic sample();
        exp_t e, a;
        cyc++;
        if (imem_req) n_ireq++;
        if (dmem_req) n_dreq++;
        if (rf_we)    n_rfwe++;
        if (pc_we) begin n_pcwe++; last_pcwe_cyc = cyc; last_pc_src = pc_src; end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a       = '0;
            a.st    = state_check;
            a.ireq  = imem_req;
            a.dreq  = dmem_req;
            a.dwe   = e.dreq ? dmem_we : 1'b0;
            a.rfwe  = rf_we;
            a.wbsel = (e.st == 3'd4) ? wb_sel : 1'b0;
            a.pcwe  = pc_we;
            a.pcsrc = e.pcwe ? pc_src : 1'b0;
            a.ill   = illegal;
            a.berr  = bus_error;
            a.op    = alu_op;
            a.chk   = e.chk;
            a.src   = e.chk ? alu_src : 1'b0;
            a.sel   = e.chk ? imm_sel : 2'd0;
            a.ret   = retired;
            tests++;
            if (a !== e) begin
                fails++;
                $display("[TB] FAIL trace cycle %0d: got st=%0d strobes=%b op=%0d src=%b sel=%0d ret=%0d, expected st=%0d strobes=%b op=%0d src=%b sel=%0d ret=%0d",
                         cyc - start_cyc, a.st, {a.ireq, a.dreq, a.dwe, a.rfwe, a.wbsel, a.pcwe, a.pcsrc, a.ill, a.berr},
                         a.op, a.src, a.sel, a.ret, e.st, {e.ireq, e.dreq, e.dwe, e.rfwe, e.wbsel, e.pcwe, e.pcsrc, e.ill, e.berr},
                         e.op, e.src, e.sel, e.ret);
            end
        end
    endtask

    task automatic step();
        @(posedge clk); #2; apply_stimulus();
        @(negedge clk); sample();
    endtask

    task automatic run_queue();
        start_cyc = cyc; b_ireq = n_ireq; b_dreq = n_dreq; b_rfwe = n_rfwe; b_pcwe = n_pcwe;
        @(posedge clk); #1 reset = 1'b1; #1 apply_stimulus();
        @(negedge clk); sample();
        while (exp_q.size() > 0) step();
    endtask

    task automatic settle();
        @(posedge clk); #1;
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0; n_ireq = 0; n_dreq = 0; n_rfwe = 0; n_pcwe = 0;
        last_pcwe_cyc = 0; last_pc_src = 1'b0;
        reset_all();
        imem_ready = 1'b1; dmem_ready = 1'b1;
        #12;
        check_output("reset state", 32'(state_check), 32'd0);
        check_output("reset imem_req", 32'(imem_req), 32'd0);
        check_output("reset retired", retired, 32'd0);
        check_output("reset ir", ir, 32'd0);
        check_output("reset flags", 32'({illegal, bus_error}), 32'd0);

        // add x7,x6,x5
        reset_all();
        queue_instr(32'h005303b3, 0, 0, 0);
        run_queue();
        check_output("add cycles", 32'(last_pcwe_cyc - start_cyc), 32'd4);
        check_output("add pc_we pulses", 32'(n_pcwe - b_pcwe), 32'd1);
        settle();
        check_output("add retired", retired, 32'd1);
        check_output("add ir", ir, 32'h005303b3);

        // sub x8,x6,x5 / and x0,x1,x2 / addi x1,x0,5 / sw x6,0(x5) back to back
        reset_all();
        queue_instr(32'h40530433, 2, 0, 0);
        queue_instr(32'h0020f033, 0, 0, 0);
        queue_instr(32'h00500093, 1, 0, 0);
        queue_instr(32'h0062a023, 0, 1, 0);
        run_queue();
        check_output("prog rf_we pulses", 32'(n_rfwe - b_rfwe), 32'd2);
        check_output("prog pc_we pulses", 32'(n_pcwe - b_pcwe), 32'd4);
        settle();
        check_output("prog retired", retired, 32'd4);

        // lw x6,0(x5), data ready on the 4th request cycle
        reset_all();
        queue_instr(32'h0002a303, 0, 3, 0);
        run_queue();
        check_output("lw dmem_req cycles", 32'(n_dreq - b_dreq), 32'd4);
        check_output("lw cycles", 32'(last_pcwe_cyc - start_cyc), 32'd8);
        settle();
        check_output("lw retired", retired, 32'd1);

        // beq x5,x6,8 taken and not taken
        reset_all();
        zero = 1'b1;
        queue_instr(32'h00628463, 0, 0, 0);
        run_queue();
        check_output("beq taken pc_src", 32'(last_pc_src), 32'd1);
        check_output("beq rf_we pulses", 32'(n_rfwe - b_rfwe), 32'd0);
        check_output("beq cycles", 32'(last_pcwe_cyc - start_cyc), 32'd3);
        reset_all();
        zero = 1'b0;
        queue_instr(32'h00628463, 0, 0, 0);
        run_queue();
        check_output("beq not taken pc_src", 32'(last_pc_src), 32'd0);

        // all-zero word is illegal; imem_ready held high throughout HALT
        reset_all();
        iready_always = 1'b1;
        queue_instr(32'h00000000, 0, 0, 20);
        run_queue();
        check_output("illegal flag", 32'(illegal), 32'd1);
        check_output("illegal pc_we pulses", 32'(n_pcwe - b_pcwe), 32'd0);
        check_output("illegal retired", retired, 32'd0);
        check_output("illegal state", 32'(state_check), 32'd5);

        // srai is outside the subset
        reset_all();
        queue_instr(32'h40505093, 0, 0, 3);
        run_queue();
        check_output("srai illegal", 32'(illegal), 32'd1);

        // instruction fetch never answered
        reset_all();
        queue_instr(32'h005303b3, -1, 0, 4);
        run_queue();
        check_output("itimeout imem_req cycles", 32'(n_ireq - b_ireq), 32'd16);
        check_output("itimeout bus_error", 32'(bus_error), 32'd1);
        check_output("itimeout state", 32'(state_check), 32'd5);
        check_output("itimeout imem_req", 32'(imem_req), 32'd0);

        // store never answered
        reset_all();
        queue_instr(32'h0062a023, 0, -1, 3);
        run_queue();
        check_output("dtimeout dmem_req cycles", 32'(n_dreq - b_dreq), 32'd16);
        check_output("dtimeout bus_error", 32'(bus_error), 32'd1);

        // reset pulse while a store waits in MEMORY
        reset_all();
        queue_instr(32'h005303b3, 0, 0, 0);
        prog_i.push_back(32'h0062a023); prog_fw.push_back(0); prog_mw.push_back(-1);
        run_queue();
        repeat (4) step();
        check_output("sw waiting state", 32'(state_check), 32'd3);
        check_output("sw waiting dmem_we", 32'({dmem_req, dmem_we}), 32'd3);
        check_output("sw waiting retired", retired, 32'd1);
        #1 reset = 1'b0;
        #1;
        check_output("async reset dmem_req", 32'(dmem_req), 32'd0);
        check_output("async reset state", 32'(state_check), 32'd0);
        check_output("async reset retired", retired, 32'd0);
        dmem_ready = 1'b1;
        @(posedge clk); #1 reset = 1'b1; #1 apply_stimulus();
        @(negedge clk);
        check_output("post reset state", 32'(state_check), 32'd0);
        check_output("post reset imem_req", 32'(imem_req), 32'd1);
        check_output("post reset flags", 32'({illegal, bus_error}), 32'd0);
        check_output("post reset retired", retired, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
